menu_text_arbiter: RTL and testbench
====================================

// Module: menu_text_arbiter
// PURPOSE
//  Owns the game-menu text buffer (ROWS x COLS chars) as single-port storage shared by two requesters.
//  Requesters: the HDMI scanout path (character lookup feeding the font ROM) and the SoC name writer.
//  Scanout reads have absolute priority with fixed latency; SoC writes are buffered in a small FIFO
//  and drained in free cycles. A clear sequencer fills the buffer with FILL_CHAR after reset or on command.
// PARAMETERS
//  ROWS       8      menu rows
//  COLS       16     characters per row
//  FILL_CHAR  8'h20  value written by clear; also returned for out-of-range reads
//  WR_DEPTH   4      write FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1  pixel clock, all logic on rising edge
//  reset      in   1  synchronous, active-high
//  vid_req    in   1  scanout read request this cycle
//  vid_row    in   3  scanout row (0..ROWS-1)
//  vid_col    in   4  scanout column (0..COLS-1)
//  vid_char   out  8  read data, registered
//  vid_valid  out  1  high the cycle after vid_req
//  wr_valid   in   1  SoC write request
//  wr_ready   out  1  write accepted when wr_valid & wr_ready
//  wr_row     in   3  write row
//  wr_col     in   4  write column
//  wr_ch      in   8  write character
//  clr_start  in   1  one-cycle clear command
//  busy       out  1  clear active or FIFO non-empty
// BEHAVIOUR
//  Reset: vid_char=0, vid_valid=0, wr_ready=0, busy=1, FIFO emptied, clear pointer=0, state=CLEAR.
//   Reset asserted mid-clear or mid-drain aborts the operation and restarts the clear from address 0.
//  Address = row*COLS + col. Width ceil(log2(ROWS*COLS)).
//  Per-cycle arbitration, one memory access per cycle:
//   1. vid_req: read. vid_char <= mem[addr] (FILL_CHAR if out of range); vid_valid=1 next cycle.
//   2. Otherwise, in CLEAR: write FILL_CHAR at pointer, pointer+1.
//   3. Otherwise, FIFO non-empty: pop one entry and write it. Out-of-range entries are popped and dropped.
//  With no vid_req, vid_char holds its value and vid_valid=0.
//  Same-cycle read/write of one address: the read wins and returns the old data.
//   The deferred write is visible to any read two or more cycles after it is performed.
//  FIFO:
//   - wr_ready = !full && state==IDLE.
//   - Push and pop in the same cycle are both honoured; occupancy is unchanged.
//   - A push when full cannot occur.
//  States:
//   - IDLE:  clr_start -> DRAIN.
//   - DRAIN: wr_ready=0; FIFO drains by rule 3; FIFO empty -> CLEAR.
//       Writes accepted before the command are never lost or reordered after the clear.
//   - CLEAR: wr_ready=0; pointer==ROWS*COLS-1 and written -> IDLE, pointer=0.
//       A clear stalls, without skipping, on every cycle that has vid_req.
//  clr_start outside IDLE is ignored. busy = (state!=IDLE) || FIFO non-empty.
//  Throughput: with vid_req at most 1 of 8 cycles, a full clear ends within ceil(ROWS*COLS*8/7)+1 cycles
//   of entering CLEAR.
// STRUCTURE
//  Package menu_text_pkg holds:
//   - ROWS, COLS, FILL_CHAR defaults
//   - derived address width
//   - state encoding {IDLE, DRAIN, CLEAR}
//   - function rc_to_addr(row, col)
//  Sub-module menu_wr_fifo: synchronous FIFO, WR_DEPTH x 15 bits {row,col,ch}, ports push/pop/full/empty.
//  Storage is a plain array inferred as a single-port RAM; the arbiter owns its only port.
// TESTING
//  1. Post-reset clear: deassert reset, no traffic.
//     -> wr_ready low 128 cycles then high; every vid_req read returns 8'h20; busy falls on the same cycle.
//  2. Write/read: write (2,5,8'h41), then vid_req (2,5) 3 cycles later.
//     -> vid_valid=1 and vid_char=8'h41 on the next cycle.
//  3. Collision: vid_req (1,1) every cycle for 10 cycles while writing (1,1,8'h7A).
//     -> all reads return 8'h20; wr_ready drops once 4 writes are queued;
//     -> the first read after vid_req stops returns 8'h7A.
//  4. Clear ordering: queue 3 writes, pulse clr_start on the same cycle.
//     -> the 3 writes land first; final buffer is all 8'h20; wr_ready=0 until the clear completes.
//  5. Clear under scanout: clr_start with vid_req 1 cycle in 8.
//     -> IDLE reached in <=148 cycles; every location = 8'h20; no read-latency change.
//  6. Reset mid-clear at pointer 60: pre-fill the buffer with 8'h41, clear, assert reset at pointer 60.
//     -> the clear restarts from 0 and all 128 locations end at 8'h20.

Source files
------------

// File: rtl/menu_text_pkg.sv
// Shared constants, state encoding and address helpers for the menu text buffer.
package menu_text_pkg;

    localparam int unsigned ROWS      = 8;
    localparam int unsigned COLS      = 16;
    localparam logic [7:0]  FILL_CHAR = 8'h20;
    localparam int unsigned CELLS     = ROWS * COLS;
    localparam int unsigned ADDR_W    = $clog2(CELLS);
    localparam int unsigned ROW_W     = 3;
    localparam int unsigned COL_W     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StClear
    } state_e;

    function automatic logic [ADDR_W-1:0] rc_to_addr(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return ADDR_W'(32'(row) * COLS + 32'(col));
    endfunction

    function automatic logic in_range(input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col);
        return (32'(row) < ROWS) && (32'(col) < COLS);
    endfunction

endpackage

// File: rtl/menu_wr_fifo.sv
// Small synchronous FIFO holding queued SoC character writes as {row, col, ch}.
module menu_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/menu_text_arbiter.sv
// Menu text buffer with one RAM port shared by scanout reads (priority), a clear
// sequencer and a buffered SoC write path.
module menu_text_arbiter #(
    parameter logic [7:0]  FILL_CHAR = 8'h20,
    parameter int unsigned WR_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vid_req,
    input  logic [2:0] vid_row,
    input  logic [3:0] vid_col,
    output logic [7:0] vid_char,
    output logic       vid_valid,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [3:0] wr_col,
    input  logic [7:0] wr_ch,
    input  logic       clr_start,
    output logic       busy
);

    import menu_text_pkg::*;

    localparam int unsigned FIFO_W = ROW_W + COL_W + 8;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [7:0]        vid_char_q;
    logic              vid_valid_q;
    logic [7:0]        mem [CELLS];

    logic              push, pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
    logic [ROW_W-1:0]  q_row;
    logic [COL_W-1:0]  q_col;
    logic [7:0]        q_ch;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    assign wr_ready   = !fifo_full && (state_q == StIdle);
    assign push       = wr_valid && wr_ready;
    assign fifo_wdata = {wr_row, wr_col, wr_ch};
    assign {q_row, q_col, q_ch} = fifo_rdata;
    assign busy       = (state_q != StIdle) || !fifo_empty;
    assign vid_char   = vid_char_q;
    assign vid_valid  = vid_valid_q;

    menu_wr_fifo #(
        .DEPTH(WR_DEPTH),
        .WIDTH(FIFO_W)
    ) u_wr_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(fifo_wdata),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        pop       = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = FILL_CHAR;

        unique case (state_q)
            StIdle: begin
                if (clr_start) state_d = StDrain;
            end
            StDrain: begin
                if (fifo_empty) state_d = StClear;
            end
            StClear: begin
                // Scanout owns the port this cycle; the pointer waits rather than skips.
                if (!vid_req) begin
                    mem_we = 1'b1;
                    if (clr_ptr_q == ADDR_W'(CELLS - 1)) begin
                        state_d   = StIdle;
                        clr_ptr_d = '0;
                    end else begin
                        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = StClear;
        endcase

        if ((state_q != StClear) && !vid_req && !fifo_empty) begin
            pop       = 1'b1;
            mem_we    = in_range(q_row, q_col);
            mem_waddr = rc_to_addr(q_row, q_col);
            mem_wdata = q_ch;
        end

        if (reset) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StClear;
            clr_ptr_q   <= '0;
            vid_char_q  <= 8'h00;
            vid_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            vid_valid_q <= vid_req;
            if (vid_req) begin
                vid_char_q <= in_range(vid_row, vid_col) ?
                              mem[rc_to_addr(vid_row, vid_col)] : FILL_CHAR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_menu_text_arbiter.sv
// Scoreboard bench for menu_text_arbiter: expected read data queued at request time.
module tb_menu_text_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       vid_req;
    logic [2:0] vid_row;
    logic [3:0] vid_col;
    logic [7:0] vid_char;
    logic       vid_valid;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [3:0] wr_col;
    logic [7:0] wr_ch;
    logic       clr_start;
    logic       busy;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];
    logic [7:0] ref_mem [128];
    logic       req_s, rst_s, exp_v;
    logic [7:0] exp_c;

    menu_text_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .vid_req  (vid_req),
        .vid_row  (vid_row),
        .vid_col  (vid_col),
        .vid_char (vid_char),
        .vid_valid(vid_valid),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_ch    (wr_ch),
        .clr_start(clr_start),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Read-path monitor: valid one cycle after each request, data in request order.
    always begin
        @(posedge clk);
        req_s = vid_req;
        rst_s = reset;
        #1;
        exp_v = req_s && !rst_s;
        n_cmp++;
        if (vid_valid !== exp_v) begin
            n_err++;
            $display("FAIL vid_valid at %0t: got %b want %b", $time, vid_valid, exp_v);
        end
        if (exp_v) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL vid_char at %0t: got %h want <no queued read>", $time, vid_char);
            end else begin
                exp_c = sb_q.pop_front();
                if (vid_char !== exp_c) begin
                    n_err++;
                    $display("FAIL vid_char at %0t: got %h want %h", $time, vid_char, exp_c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_read(input int a, input logic [7:0] exp);
        vid_req = 1'b1;
        vid_row = 3'(a / 16);
        vid_col = 4'(a % 16);
        sb_q.push_back(exp);
    endtask

    task automatic drive_write(input int a, input logic [7:0] ch);
        wr_valid = 1'b1;
        wr_row   = 3'(a / 16);
        wr_col   = 4'(a % 16);
        wr_ch    = ch;
    endtask

    task automatic read_all();
        for (int a = 0; a < 128; a++) begin
            drive_read(a, ref_mem[a]);
            tick();
        end
        vid_req = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy got %b want 0 within 400 cycles", busy);
        end
    endtask

    // Counts cycles with wr_ready low from now; a full unstalled clear takes 128.
    task automatic measure_clear(input string name);
        int low = 0;
        while (wr_ready !== 1'b1 && low < 300) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy during clear: got %b want 1", name, busy);
            end
            low++;
            tick();
        end
        n_cmp++;
        if (low != 128) begin
            n_err++;
            $display("FAIL %s clear length: got %0d want 128", name, low);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy at clear end: got %b want 0", name, busy);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_cmp += 4;
        if (vid_valid !== 1'b0) begin
            n_err++; $display("FAIL %s vid_valid: got %b want 0", name, vid_valid);
        end
        if (vid_char !== 8'h00) begin
            n_err++; $display("FAIL %s vid_char: got %h want 00", name, vid_char);
        end
        if (wr_ready !== 1'b0) begin
            n_err++; $display("FAIL %s wr_ready: got %b want 0", name, wr_ready);
        end
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL %s busy: got %b want 1", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; vid_req = 1'b0; vid_row = '0; vid_col = '0;
        wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_ch = '0; clr_start = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
    endtask

    task automatic test_post_reset_clear();
        reset = 1'b0;
        measure_clear("post_reset");
        for (int a = 0; a < 128; a++) ref_mem[a] = 8'h20;
        read_all();
    endtask

    task automatic test_write_read();
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_err++; $display("FAIL write_read wr_ready: got %b want 1", wr_ready);
        end
        drive_write(37, 8'h41);
        tick();
        wr_valid = 1'b0;
        ref_mem[37] = 8'h41;
        repeat (3) tick();
        drive_read(37, 8'h41);
        tick();
        vid_req = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        int acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive_read(17, ref_mem[17]);
            drive_write(17, 8'h7A);
            n_cmp++;
            if (wr_ready !== (acc < 4)) begin
                n_err++;
                $display("FAIL collision wr_ready cycle %0d: got %b want %b", i, wr_ready, acc < 4);
            end
            if (wr_ready === 1'b1) acc++;
            tick();
        end
        vid_req = 1'b0;
        wr_valid = 1'b0;
        n_cmp++;
        if (acc != 4) begin
            n_err++; $display("FAIL collision accepted: got %0d want 4", acc);
        end
        ref_mem[17] = 8'h7A;
        tick();
        drive_read(17, 8'h7A);
        tick();
        vid_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_clear_ordering();
        int addrs[3] = '{51, 68, 85};
        for (int i = 0; i < 3; i++) begin
            drive_read(0, ref_mem[0]);
            drive_write(addrs[i], 8'h51 + 8'(i));
            clr_start = (i == 2);
            n_cmp++;
            if (wr_ready !== 1'b1) begin
                n_err++; $display("FAIL ordering wr_ready queue %0d: got %b want 1", i, wr_ready);
            end
            tick();
        end
        vid_req = 1'b0; wr_valid = 1'b0; clr_start = 1'b0;
        for (int i = 0; i < 3; i++) ref_mem[addrs[i]] = 8'h51 + 8'(i);
        repeat (3) begin
            n_cmp++;
            if (wr_ready !== 1'b0) begin
                n_err++; $display("FAIL ordering wr_ready in drain: got %b want 0", wr_ready);
            end
            tick();
        end
        drive_read(85, ref_mem[85]);
        tick();
        drive_read(68, ref_mem[68]);
        tick();
        drive_read(51, ref_mem[51]);
        tick();
        vid_req = 1'b0;
        measure_clear("ordering");
        for (int a = 0; a < 128; a++) ref_mem[a] = 8'h20;
        read_all();
    endtask

    task automatic test_clear_under_scanout();
        int cnt;
        drive_write(0, 8'h61);
        tick();
        drive_write(127, 8'h62);
        tick();
        wr_valid = 1'b0;
        wait_idle();
        ref_mem[0] = 8'h61;
        ref_mem[127] = 8'h62;
        clr_start = 1'b1;
        drive_read(96, 8'h20);
        tick();
        clr_start = 1'b0;
        vid_req = 1'b0;
        cnt = 1;
        while (wr_ready !== 1'b1 && cnt < 300) begin
            if (cnt % 8 == 0) drive_read(96, 8'h20);
            else vid_req = 1'b0;
            tick();
            cnt++;
        end
        vid_req = 1'b0;
        n_cmp++;
        if (cnt > 148 || cnt < 130) begin
            n_err++; $display("FAIL scanout_clear cycles: got %0d want 130..148", cnt);
        end
        tick();
        for (int a = 0; a < 128; a++) ref_mem[a] = 8'h20;
        read_all();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        for (int a = 0; a < 128; a++) begin
            drive_write(a, 8'h41);
            n = 0;
            while (wr_ready !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            tick();
        end
        wr_valid = 1'b0;
        wait_idle();
        for (int a = 0; a < 128; a++) ref_mem[a] = 8'h41;
        drive_read(0, 8'h41);
        tick();
        drive_read(127, 8'h41);
        tick();
        vid_req = 1'b0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        repeat (60) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("mid_clear_reset");
        for (int a = 0; a < 60; a++) ref_mem[a] = 8'h20;
        drive_read(61, ref_mem[61]);
        tick();
        drive_read(59, ref_mem[59]);
        tick();
        drive_read(127, ref_mem[127]);
        tick();
        vid_req = 1'b0;
        measure_clear("mid_clear");
        for (int a = 0; a < 128; a++) ref_mem[a] = 8'h20;
        read_all();
    endtask

    initial begin
        test_reset();
        test_post_reset_clear();
        test_write_read();
        test_collision();
        test_clear_ordering();
        test_clear_under_scanout();
        test_reset_mid_clear();
        tick();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
